// File: rtl/ssd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ssd_arbiter_pkg
//   Shared types and constants for the seven-segment display arbiter.
//   The display constants mirror what ssd_driver expects on its val input:
//   four hex digits, 16 bits, and nibble 0 rendered as a dash. That makes
//   an all-zero word read as "----".
// ---------------------------------------------------------------------------
package ssd_arbiter_pkg;

    localparam logic [15:0] SSD_DASH   = 16'h0000;
    localparam int          SSD_DIGITS = 4;
    localparam int          SSD_VAL_W  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } arb_state_t;

    // Next index after p, wrapping at n. Used only for grant-index arithmetic.
    function automatic int wrap_idx(input int p, input int step, input int n);
        return (p + step) % n;
    endfunction

endpackage

// File: rtl/ssd_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. It scans (ptr+1, ptr+2, ... ptr) mod
//   N_REQ over the requests that are not masked and returns the first one
//   that is set. Because ptr is scanned last, the previous owner can win
//   again only if it is the sole remaining requester.
//
// Ports
//   req     in  N_REQ   raw request vector
//   mask    in  N_REQ   requests to ignore this cycle
//   ptr     in  PTR_W   index of the last owner; the scan starts after it
//   found   out 1       some unmasked request exists
//   idx     out PTR_W   winning index (0 when found=0)
//   onehot  out N_REQ   one-hot winner (all-zero when found=0)
// ---------------------------------------------------------------------------
module rr_pick
    import ssd_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [N_REQ-1:0] eff_req;

    assign eff_req = req & ~mask;

    // Walk the scan order backwards so that the last hit written is the
    // nearest one after ptr, which is the round-robin winner.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            int c;
            c = wrap_idx(int'(ptr), i, N_REQ);
            if (eff_req[c]) begin
                found = 1'b1;
                idx   = PTR_W'(c);
            end
        end
    end

    always_comb begin
        onehot = '0;
        if (found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ssd_arbiter.sv
// ---------------------------------------------------------------------------
// ssd_arbiter
//   Time-shares one 4-digit seven-segment display among N_REQ requesters.
//   Owners are chosen round-robin and each grant is held for DWELL_CYCLES
//   clocks unless the owner withdraws. disp_val feeds ssd_driver.val; with
//   no owner it is all-zero, which the driver shows as "----".
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no owner; grant=0, display dashes, waiting for any req
//   ST_SHOW | one owner granted; dwell counter running (or paused by lock)
//
// Parameters
//   N_REQ         number of requesters (2..8)
//   DWELL_CYCLES  clocks per grant (>= 2)
//   CNT_W         dwell counter width, 2**CNT_W > DWELL_CYCLES
//
// Ports
//   clk       in   1          system clock
//   rst_n     in   1          asynchronous active-low reset
//   req       in   N_REQ      level request per requester
//   vals      in   16*N_REQ   display value of requester i at [16*i +: 16]
//   lock      in   1          freeze current grant and pause dwell count
//   grant     out  N_REQ      one-hot current owner, zero when idle
//   done      out  N_REQ      one-cycle pulse on the owner whose dwell expired
//   disp_val  out  16         value to show on the display
// ---------------------------------------------------------------------------
module ssd_arbiter
    import ssd_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [SSD_VAL_W*N_REQ-1:0] vals,
    input  logic                       lock,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           done,
    output logic [SSD_VAL_W-1:0]       disp_val
);

    localparam int               PTR_W      = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_RESET  = PTR_W'(N_REQ - 1);

    arb_state_t       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] own;
    logic [CNT_W-1:0] cnt;

    logic                 own_req;
    logic [SSD_VAL_W-1:0] own_val;
    logic [N_REQ-1:0]     pick_mask;
    logic [PTR_W-1:0]     pick_ptr;
    logic                 pick_found;
    logic [PTR_W-1:0]     pick_idx;
    logic [N_REQ-1:0]     pick_onehot;

    assign own_req = req[own];
    assign own_val = vals[own*SSD_VAL_W +: SSD_VAL_W];

    // While showing, every re-pick (withdrawal or expiry) starts right after
    // the current owner, so the picker sees own as its pointer. ptr is
    // updated to own on the same edge, keeping the two views consistent.
    assign pick_ptr  = (state == ST_SHOW) ? own : ptr;
    // A withdrawn owner is masked explicitly so a glitchy req can never
    // hand the grant straight back to it.
    assign pick_mask = (state == ST_SHOW && !own_req) ? grant : '0;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .mask   (pick_mask),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= PTR_RESET;
            own      <= '0;
            cnt      <= '0;
            grant    <= '0;
            done     <= '0;
            disp_val <= SSD_DASH;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    disp_val <= SSD_DASH;
                    if (pick_found) begin
                        grant <= pick_onehot;
                        own   <= pick_idx;
                        cnt   <= DWELL_LOAD;
                        state <= ST_SHOW;
                    end
                end

                ST_SHOW: begin
                    disp_val <= own_val;
                    if (!own_req) begin
                        // Withdrawal beats lock and expiry; no done pulse.
                        ptr <= own;
                        if (pick_found) begin
                            grant <= pick_onehot;
                            own   <= pick_idx;
                            cnt   <= DWELL_LOAD;
                        end else begin
                            grant <= '0;
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end else if (lock) begin
                        // Hold everything; dwell resumes where it left off.
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Expiry: own still requests, so the picker always
                        // finds someone, possibly own again if it is alone.
                        done  <= grant;
                        ptr   <= own;
                        grant <= pick_onehot;
                        own   <= pick_idx;
                        cnt   <= DWELL_LOAD;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_arbiter.sv
module tb_ssd_arbiter;

    localparam int N_REQ = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] vals;
    logic        lock;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [15:0] disp_val;

    int n_checks = 0;
    int n_pass   = 0;

    ssd_arbiter #(
        .N_REQ        (N_REQ),
        .DWELL_CYCLES (4),
        .CNT_W        (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .vals     (vals),
        .lock     (lock),
        .grant    (grant),
        .done     (done),
        .disp_val (disp_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = '0;
        vals  = '0;
        lock  = 1'b0;

        // 1: reset asserted mid-cycle takes effect at once
        #12;
        rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_disp", 32'(disp_val), 32'h0);
        #4;
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_disp", 32'(disp_val), 32'h0);

        // 2: single requester, dwell of 4, re-granted to itself
        vals[15:0] = 16'h1234;
        req = 4'b0001;
        step();
        chk("t2_grant", 32'(grant), 32'h1);
        step();
        chk("t2_disp", 32'(disp_val), 32'h1234);
        step();
        step();
        chk("t2_hold_grant", 32'(grant), 32'h1);
        chk("t2_no_done", 32'(done), 32'h0);
        step();
        chk("t2_done", 32'(done), 32'h1);
        chk("t2_regrant", 32'(grant), 32'h1);
        step();
        chk("t2_done_clr", 32'(done), 32'h0);
        req = 4'b0000;
        step();
        chk("t2_release", 32'(grant), 32'h0);
        chk("t2_release_done", 32'(done), 32'h0);
        step();
        chk("t2_dash", 32'(disp_val), 32'h0);

        // 3: round-robin over 1011 from reset pointer
        pulse_reset();
        vals = 64'h4444_3333_2222_1111;
        req = 4'b1011;
        step();
        chk("t3_g0", 32'(grant), 32'h1);
        step();
        chk("t3_disp0", 32'(disp_val), 32'h1111);
        step();
        step();
        chk("t3_g0_hold", 32'(grant), 32'h1);
        step();
        chk("t3_done0", 32'(done), 32'h1);
        chk("t3_g1", 32'(grant), 32'h2);
        step();
        chk("t3_disp1", 32'(disp_val), 32'h2222);
        step();
        step();
        chk("t3_g1_hold", 32'(grant), 32'h2);
        step();
        chk("t3_done1", 32'(done), 32'h2);
        chk("t3_g3", 32'(grant), 32'h8);
        step();
        chk("t3_disp3", 32'(disp_val), 32'h4444);
        step();
        step();
        step();
        chk("t3_done3", 32'(done), 32'h8);
        chk("t3_g0_again", 32'(grant), 32'h1);

        // 4: owner 1 withdraws mid-dwell
        pulse_reset();
        req = 4'b0110;
        step();
        chk("t4_g1", 32'(grant), 32'h2);
        step();
        req = 4'b0100;
        step();
        chk("t4_g2", 32'(grant), 32'h4);
        chk("t4_no_done", 32'(done), 32'h0);
        step();
        chk("t4_disp2", 32'(disp_val), 32'h3333);
        req = 4'b0000;
        step();
        chk("t4_idle", 32'(grant), 32'h0);

        // 5: lock pauses the dwell count
        pulse_reset();
        vals[15:0] = 16'h5555;
        req = 4'b0011;
        step();
        chk("t5_grant", 32'(grant), 32'h1);
        step();
        step();
        lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_lock_grant", 32'(grant), 32'h1);
            chk("t5_lock_done", 32'(done), 32'h0);
        end
        chk("t5_lock_disp", 32'(disp_val), 32'h5555);
        lock = 1'b0;
        step();
        chk("t5_resume_grant", 32'(grant), 32'h1);
        chk("t5_resume_nodone", 32'(done), 32'h0);
        step();
        chk("t5_expire_done", 32'(done), 32'h1);
        chk("t5_expire_grant", 32'(grant), 32'h2);
        lock = 1'b1;
        req = 4'b0001;
        step();
        chk("t5_lock_drop", 32'(grant), 32'h1);
        chk("t5_lock_drop_done", 32'(done), 32'h0);
        lock = 1'b0;

        // 6: live value tracking for the owner only
        pulse_reset();
        vals = 64'h0;
        vals[15:0]  = 16'h00AB;
        vals[31:16] = 16'h7777;
        req = 4'b0001;
        step();
        step();
        chk("t6_disp_ab", 32'(disp_val), 32'h00AB);
        vals[15:0] = 16'hBEEF;
        #1;
        chk("t6_disp_reg", 32'(disp_val), 32'h00AB);
        step();
        chk("t6_disp_beef", 32'(disp_val), 32'hBEEF);
        vals[31:16] = 16'h1111;
        step();
        chk("t6_nonowner", 32'(disp_val), 32'hBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
